// File: rtl/pkt_sf_pkg.sv
// Shared types for the store-and-forward packet buffer.
// RAM entry layout and write-side FSM states.
package pkt_sf_pkg;

   localparam int DATA_W = 64;

   typedef struct packed {
      logic              eop;
      logic [DATA_W-1:0] data;
   } pkt_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      OPEN,
      DISCARD
   } wr_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read data is valid the cycle after i_re.
module sdp_ram #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
      if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_sf_buffer.sv
// Store-and-forward TLP buffer: packets are released only once their
// eop beat is stored clean; errored, truncated or overflowing ones drop.
module pkt_sf_buffer
   import pkt_sf_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 32
) (
   input  logic              clock_clk,
   input  logic              clock_rst,
   input  logic [63:0]       asi_data,
   input  logic              asi_valid,
   output logic              asi_ready,
   input  logic              asi_startofpacket,
   input  logic              asi_endofpacket,
   input  logic              asi_error,
   output logic [63:0]       aso_data,
   output logic              aso_valid,
   input  logic              aso_ready,
   output logic              aso_startofpacket,
   output logic              aso_endofpacket,
   output logic              aso_error,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

   wr_state_t         r_state;
   wr_state_t         w_state_nx;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_wr_commit;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] w_wr_ptr_nx;
   logic [ADDR_W-1:0] w_wr_commit_nx;
   logic [ADDR_W-1:0] w_waddr;
   logic              r_bad;
   logic              w_bad_nx;
   logic              w_we;
   logic              w_acc;
   logic              w_full_ptr;
   logic              w_full_cmt;
   logic              w_drop_trunc;
   logic              w_drop_pkt;
   logic [CNT_W-1:0]  r_drop;
   logic [CNT_W:0]    w_drop_sum;
   logic [CNT_W-1:0]  r_pkt;

   pkt_entry_t        w_wentry;
   pkt_entry_t        w_rentry;
   pkt_entry_t        r_sk0;
   pkt_entry_t        r_sk1;
   logic [1:0]        r_sk_cnt;
   logic              r_inflight;
   logic              r_sop_nx;
   logic              w_pop;
   logic              w_re;
   logic [2:0]        w_occ;

   assign asi_ready  = ~clock_rst;
   assign w_acc      = asi_valid & asi_ready;
   assign w_full_ptr = (r_wr_ptr + A_ONE) == r_rd_ptr;
   assign w_full_cmt = (r_wr_commit + A_ONE) == r_rd_ptr;

   assign w_wentry.eop  = asi_endofpacket;
   assign w_wentry.data = asi_data;

   always_ff @(posedge clock_clk) begin
      if (clock_rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_wr_commit <= '0;
         r_bad       <= 1'b0;
         r_drop      <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_wr_ptr    <= w_wr_ptr_nx;
         r_wr_commit <= w_wr_commit_nx;
         r_bad       <= w_bad_nx;
         r_drop      <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_wr_ptr_nx    = r_wr_ptr;
      w_wr_commit_nx = r_wr_commit;
      w_bad_nx       = r_bad;
      w_we           = 1'b0;
      w_waddr        = r_wr_ptr;
      w_drop_trunc   = 1'b0;
      w_drop_pkt     = 1'b0;
      if (w_acc && asi_startofpacket) begin
         // A new sop always restarts from the last committed boundary.
         w_drop_trunc = (r_state != IDLE);
         w_wr_ptr_nx  = r_wr_commit;
         w_waddr      = r_wr_commit;
         if (w_full_cmt) begin
            w_drop_pkt = asi_endofpacket;
            w_state_nx = asi_endofpacket ? IDLE : DISCARD;
         end else begin
            w_we = 1'b1;
            if (asi_endofpacket) begin
               w_state_nx = IDLE;
               if (asi_error) begin
                  w_drop_pkt = 1'b1;
               end else begin
                  w_wr_commit_nx = r_wr_commit + A_ONE;
                  w_wr_ptr_nx    = r_wr_commit + A_ONE;
               end
            end else begin
               w_wr_ptr_nx = r_wr_commit + A_ONE;
               w_bad_nx    = asi_error;
               w_state_nx  = OPEN;
            end
         end
      end else if (w_acc) begin
         unique case (r_state)
            IDLE: begin
               w_drop_pkt = asi_endofpacket;
            end
            OPEN: begin
               if (w_full_ptr) begin
                  w_wr_ptr_nx = r_wr_commit;
                  w_drop_pkt  = asi_endofpacket;
                  w_state_nx  = asi_endofpacket ? IDLE : DISCARD;
               end else begin
                  w_we = 1'b1;
                  if (asi_endofpacket) begin
                     w_state_nx = IDLE;
                     if (r_bad | asi_error) begin
                        w_wr_ptr_nx = r_wr_commit;
                        w_drop_pkt  = 1'b1;
                     end else begin
                        w_wr_ptr_nx    = r_wr_ptr + A_ONE;
                        w_wr_commit_nx = r_wr_ptr + A_ONE;
                     end
                  end else begin
                     w_wr_ptr_nx = r_wr_ptr + A_ONE;
                     w_bad_nx    = r_bad | asi_error;
                  end
               end
            end
            DISCARD: begin
               if (asi_endofpacket) begin
                  w_drop_pkt = 1'b1;
                  w_state_nx = IDLE;
               end
            end
            default: w_state_nx = IDLE;
         endcase
      end
   end

   // Up to two drops land in one cycle: a truncation plus an instant drop.
   assign w_drop_sum = {1'b0, r_drop}
                     + (CNT_W+1)'(w_drop_trunc)
                     + (CNT_W+1)'(w_drop_pkt);

   sdp_ram #(
      .WIDTH ($bits(pkt_entry_t)),
      .DEPTH (2**ADDR_W),
      .AW    (ADDR_W)
   ) u_ram (
      .clk     (clock_clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wentry),
      .i_re    (w_re),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rentry)
   );

   assign w_pop = (r_sk_cnt != 2'd0) & aso_ready;
   // Count the beat leaving this cycle so the skid never starves.
   assign w_occ = {1'b0, r_sk_cnt}
                + {2'b00, r_inflight}
                - {2'b00, w_pop};
   assign w_re  = (r_rd_ptr != r_wr_commit) && (w_occ < 3'd2);

   always_ff @(posedge clock_clk) begin
      if (clock_rst) begin
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
         r_sk_cnt   <= 2'd0;
         r_sk0      <= '0;
         r_sk1      <= '0;
         r_sop_nx   <= 1'b1;
         r_pkt      <= '0;
      end else begin
         if (w_re)
            r_rd_ptr <= r_rd_ptr + A_ONE;
         r_inflight <= w_re;
         if (w_pop) begin
            r_sop_nx <= r_sk0.eop;
            if (r_sk0.eop)
               r_pkt <= r_pkt + CNT_W'(1);
         end
         unique case ({w_pop, r_inflight})
            2'b11: begin
               if (r_sk_cnt == 2'd1) begin
                  r_sk0 <= w_rentry;
               end else begin
                  r_sk0 <= r_sk1;
                  r_sk1 <= w_rentry;
               end
            end
            2'b10: begin
               r_sk0    <= r_sk1;
               r_sk_cnt <= r_sk_cnt - 2'd1;
            end
            2'b01: begin
               if (r_sk_cnt == 2'd0)
                  r_sk0 <= w_rentry;
               else
                  r_sk1 <= w_rentry;
               r_sk_cnt <= r_sk_cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign aso_valid         = (r_sk_cnt != 2'd0);
   assign aso_data          = r_sk0.data;
   assign aso_startofpacket = aso_valid & r_sop_nx;
   assign aso_endofpacket   = aso_valid & r_sk0.eop;
   assign aso_error         = 1'b0;
   assign pkt_count         = r_pkt;
   assign drop_count        = r_drop;

endmodule
